// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round controller.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_INIT_ROUND = 2'd1,
    ST_MID_ROUND  = 2'd2,
    ST_LAST_ROUND = 2'd3
  } aes_ctrl_state_e;

  typedef enum logic [1:0] {
    KEY_LEN_128  = 2'd0,
    KEY_LEN_192  = 2'd1,
    KEY_LEN_256  = 2'd2,
    KEY_LEN_RSVD = 2'd3
  } aes_key_len_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Number of rounds for a key length; the reserved code behaves as AES-128.
  function automatic logic [3:0] nr_of(input aes_key_len_e key_len);
    logic [3:0] nr;
    case (key_len)
      KEY_LEN_192: nr = NR_192;
      KEY_LEN_256: nr = NR_256;
      default:     nr = NR_128;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_cycle_ctr.sv
// Per-round cycle counter: loads/decrements cyc, captures key_valid into
// key_ok, and produces the round-advance and key-wait stall strobes.
module aes_round_cycle_ctr
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic active,
  input  logic key_valid,
  output logic first_cyc,
  output logic round_adv,
  output logic stall
);

  localparam int unsigned CYC_W = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(ROUND_CYCLES - 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             key_ok_q, key_ok_d;
  logic             have_key;
  logic             at_end;

  assign have_key  = key_ok_q | key_valid;
  assign at_end    = active && !clr && (cyc_q == '0);
  assign first_cyc = active && (cyc_q == CYC_MAX);
  assign round_adv = at_end && have_key;
  assign stall     = at_end && !have_key;

  // Next cycle count and key capture; abort clears, start loads.
  always_comb begin
    cyc_d    = cyc_q;
    key_ok_d = key_ok_q;
    if (clr) begin
      cyc_d    = '0;
      key_ok_d = 1'b0;
    end else if (load) begin
      cyc_d    = CYC_MAX;
      key_ok_d = 1'b0;
    end else if (active) begin
      if (round_adv) begin
        cyc_d    = CYC_MAX;
        key_ok_d = 1'b0;
      end else if (cyc_q != '0) begin
        cyc_d    = cyc_q - CYC_W'(1);
        key_ok_d = key_ok_q | key_valid;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q    <= '0;
      key_ok_q <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      key_ok_q <= key_ok_d;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round-sequencing FSM (AES-128/192/256, encrypt/decrypt) with per-round
// key handshake and abort. Optional macro AES_CTRL_STALL_CNT_EN adds the
// saturating stall_cycles counter and port.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = 3,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic [1:0] key_len,
  input  logic       abort,
  input  logic       key_valid,
  output logic       req_key,
  output logic [3:0] key_idx,
  output logic       mux_sel,
  output logic       mix_en,
  output logic       busy,
  output logic       done
`ifdef AES_CTRL_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  if (ROUND_CYCLES < 2 || ROUND_CYCLES > 8) begin : g_bad_round_cycles
    $error("ROUND_CYCLES must be within 2..8");
  end
  if (STALL_CNT_W < 1) begin : g_bad_stall_w
    $error("STALL_CNT_W must be at least 1");
  end

  aes_ctrl_state_e state_q, state_d;
  aes_key_len_e    klen_q, klen_d;
  logic            dir_q, dir_d;
  logic [3:0]      key_idx_q, key_idx_d;
  logic [3:0]      nr;
  logic            accept, clr, first_cyc, round_adv, stall;

  assign busy   = (state_q != ST_IDLE);
  assign accept = (state_q == ST_IDLE) && start;
  assign clr    = busy && abort;
  assign nr     = nr_of(klen_q);

  aes_round_cycle_ctr #(
    .ROUND_CYCLES(ROUND_CYCLES)
  ) u_cyc (
    .clk      (clk),
    .rst      (reset),
    .load     (accept),
    .clr      (clr),
    .active   (busy),
    .key_valid(key_valid),
    .first_cyc(first_cyc),
    .round_adv(round_adv),
    .stall    (stall)
  );

  // Next-state, operand latching and key index stepping.
  always_comb begin
    state_d   = state_q;
    klen_d    = klen_q;
    dir_d     = dir_q;
    key_idx_d = key_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_INIT_ROUND;
          dir_d     = dir;
          klen_d    = aes_key_len_e'(key_len);
          key_idx_d = dir ? nr_of(aes_key_len_e'(key_len)) : 4'd0;
        end
      end
      ST_INIT_ROUND: if (round_adv) state_d = ST_MID_ROUND;
      // The completed round equals key_idx (encrypt) or Nr-key_idx (decrypt),
      // so the final middle round is recognised from key_idx directly.
      ST_MID_ROUND: begin
        if (round_adv) begin
          if (dir_q ? (key_idx_q == 4'd1) : (key_idx_q == nr - 4'd1))
            state_d = ST_LAST_ROUND;
        end
      end
      ST_LAST_ROUND: if (round_adv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (busy && round_adv) begin
      if (dir_q) begin
        if (key_idx_q != 4'd0) key_idx_d = key_idx_q - 4'd1;
      end else begin
        if (key_idx_q != 4'd15) key_idx_d = key_idx_q + 4'd1;
      end
    end
    if (clr) begin
      state_d   = ST_IDLE;
      key_idx_d = '0;
    end
  end

  // FSM and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      klen_q    <= KEY_LEN_128;
      dir_q     <= 1'b0;
      key_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      klen_q    <= klen_d;
      dir_q     <= dir_d;
      key_idx_q <= key_idx_d;
    end
  end

  // Datapath and handshake outputs decoded from state.
  always_comb begin
    req_key = first_cyc;
    key_idx = key_idx_q;
    mux_sel = (state_q == ST_MID_ROUND) || (state_q == ST_LAST_ROUND);
    mix_en  = (state_q == ST_MID_ROUND);
    done    = (state_q == ST_LAST_ROUND) && round_adv;
  end

`ifdef AES_CTRL_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Key-wait stall counter, saturating, cleared on start accept.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept)
      stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed testbench for aes_round_ctrl (ROUND_CYCLES = 3).
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, dir, abort, key_valid;
  logic [1:0] key_len;
  logic       req_key, mux_sel, mix_en, busy, done;
  logic [3:0] key_idx;
`ifdef AES_CTRL_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int t_done;

  aes_round_ctrl #(
    .ROUND_CYCLES(3),
    .STALL_CNT_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dir         (dir),
    .key_len     (key_len),
    .abort       (abort),
    .key_valid   (key_valid),
    .req_key     (req_key),
    .key_idx     (key_idx),
    .mux_sel     (mux_sel),
    .mix_en      (mix_en),
    .busy        (busy),
    .done        (done)
`ifdef AES_CTRL_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Runs one operation; cycle 0 is the start-accept cycle. Keys are returned
  // in the req_key cycle except for req number stall_key, which is returned
  // stall_n cycles after that round reaches cyc == 0.
  task automatic run_op(input logic d, input logic [1:0] kl, input int nr,
                        input int stall_key, input int stall_n, input int abort_key,
                        input logic hold_start, output int done_at);
    int req_cnt = 0, mix_cnt = 0, mux0_cnt = 0, mux0_first = -1, mux0_last = -1;
    int done_cnt = 0, kv_at = -1, stall_req_n = -1, aborted_at = -1;
    int stall_k = 0;
    done_at = -1;
    start = 1'b1; dir = d; key_len = kl;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      if (done_at < 0) begin dir = ~d; key_len = ~kl; end
      else begin dir = d; key_len = kl; end
      key_valid = 1'b0;
      abort = 1'b0;
      if (req_key) begin
        chk_eq("key_idx_seq", key_idx, d ? (nr - req_cnt) : req_cnt);
        if (req_cnt == stall_key) begin
          kv_at = n + 2 + stall_n;
          stall_req_n = n;
          stall_k = key_idx;
        end else begin
          key_valid = 1'b1;
        end
        if (abort_key >= 0 && key_idx == abort_key && mix_en) begin
          abort = 1'b1;
          aborted_at = n;
        end
        req_cnt++;
      end
      if (n == kv_at) key_valid = 1'b1;
      if (stall_req_n > 0 && n > stall_req_n + 2 && n <= kv_at) begin
        chk_eq("stall_key_idx_hold", key_idx, stall_k);
        chk_eq("stall_no_rereq", req_key, 0);
      end
      #4;
      if (mix_en) mix_cnt++;
      if (busy && !mux_sel) begin
        mux0_cnt++;
        if (mux0_first < 0) mux0_first = n;
        mux0_last = n;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          chk_eq("last_mix_en", mix_en, 0);
          chk_eq("last_key_idx", key_idx, d ? 0 : nr);
        end
      end
      if (aborted_at > 0 && n == aborted_at + 1) begin
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_key_idx", key_idx, 0);
      end
      if (done_at > 0 && n == done_at + 1) begin
        chk_eq("busy_after_done", busy, 0);
        break;
      end
      if (aborted_at > 0 && n == aborted_at + 5) break;
    end
    key_valid = 1'b0;
    abort = 1'b0;
    if (abort_key >= 0) begin
      chk_eq("abort_reached", aborted_at, 3 * abort_key + 1);
      chk_eq("abort_no_done", done_cnt, 0);
    end else begin
      chk_eq("done_latency", done_at, (nr + 1) * 3 + (stall_key >= 0 ? stall_n : 0));
      chk_eq("done_pulses", done_cnt, 1);
      chk_eq("req_count", req_cnt, nr + 1);
      chk_eq("mix_cycles", mix_cnt, (nr - 1) * 3 + (stall_key > 0 ? stall_n : 0));
      chk_eq("mux0_cycles", mux0_cnt, 3);
      chk_eq("mux0_first", mux0_first, 1);
      chk_eq("mux0_last", mux0_last, 3);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; key_len = 2'd0;
    abort = 1'b0; key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_req_key", req_key, 0);
    chk_eq("rst_mux_sel", mux_sel, 0);
    chk_eq("rst_mix_en", mix_en, 0);
    chk_eq("rst_key_idx", key_idx, 0);
`ifdef AES_CTRL_STALL_CNT_EN
    chk_eq("rst_stall_cycles", stall_cycles, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Encrypt AES-128.
    run_op(1'b0, 2'd0, 10, -1, 0, -1, 1'b0, t_done);
`ifdef AES_CTRL_STALL_CNT_EN
    chk_eq("stall_cnt_none", stall_cycles, 0);
`endif
    // Decrypt AES-256.
    run_op(1'b1, 2'd2, 14, -1, 0, -1, 1'b0, t_done);
    // AES-192 encrypt with round-5 key delayed by 4 cycles.
    run_op(1'b0, 2'd1, 12, 5, 4, -1, 1'b0, t_done);
`ifdef AES_CTRL_STALL_CNT_EN
    chk_eq("stall_cnt_4", stall_cycles, 4);
    repeat (3) @(negedge clk);
    chk_eq("stall_cnt_hold", stall_cycles, 4);
`endif
    // Abort in round 6, then a full operation.
    run_op(1'b0, 2'd0, 10, -1, 0, 6, 1'b0, t_done);
    run_op(1'b0, 2'd0, 10, -1, 0, -1, 1'b0, t_done);
    // start held through busy and done; reserved key_len gives 10 rounds,
    // then the next start is taken on the first idle cycle.
    run_op(1'b0, 2'd3, 10, -1, 0, -1, 1'b1, t_done);
    run_op(1'b1, 2'd0, 10, -1, 0, -1, 1'b0, t_done);

    // Asynchronous reset in the middle of the initial round.
    @(negedge clk);
    start = 1'b1; dir = 1'b1; key_len = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk_eq("pre_rst_busy", busy, 1);
    chk_eq("pre_rst_key_idx", key_idx, 14);
    #2;
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk_eq("async_rst_busy", busy, 0);
    chk_eq("async_rst_key_idx", key_idx, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("rst_hold_outputs", {busy, done, req_key, mux_sel, mix_en, key_idx}, 0);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Parametrised AES round-sequencing FSM.
- Supports AES-128/192/256 (Nr = 10/12/14) in both encrypt and decrypt direction.
- Has a per-round key request/valid handshake with stall, and an abort input.
- Sits between the top-level start/done interface and the datapath (round mux, MixColumns enable) and the key-schedule/key-store block.

Parameters:
- ROUND_CYCLES, 3: clock cycles per round including the initial AddRoundKey round; legal range 2..8.
- STALL_CNT_W, 16: width of the optional stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request new operation; sampled only in IDLE.
- dir  in  1  0 = encrypt, 1 = decrypt; latched on start accept.
- key_len  in  2  0 = 128, 1 = 192, 2 = 256, 3 = reserved (treated as 128); latched on start accept.
- abort  in  1  synchronous abort; return to IDLE with no done.
- key_valid  in  1  key store has delivered round key key_idx.
- req_key  out  1  one-cycle request pulse for round key key_idx.
- key_idx  out  4  round-key index being requested/used.
- mux_sel  out  1  0 = datapath takes input text (initial round); 1 = feedback from state register.
- mix_en  out  1  MixColumns/InvMixColumns enable.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- stall_cycles  out  STALL_CNT_W  present only with the optional feature.

Behaviour:
- Reset: state IDLE; busy, done, req_key, mux_sel and mix_en all 0; key_idx 0; cycle counter 0; key_ok 0.
- Nr is 10/12/14 from the latched key_len; reserved value gives 10. key_idx arithmetic is 4-bit unsigned with no wrap.
- States: IDLE, INIT_ROUND, MID_ROUND, LAST_ROUND.
- IDLE -> INIT_ROUND on start.
  - Latch dir and key_len.
  - key_idx = 0 for encrypt, Nr for decrypt.
  - Cycle counter cyc = ROUND_CYCLES-1.
- Each round counts cyc down from ROUND_CYCLES-1 to 0.
  - req_key = 1 on the round's first cycle (cyc == ROUND_CYCLES-1) only.
  - key_ok is set by key_valid on any cycle of the round, including the req_key cycle.
  - key_ok clears at round advance.
- At cyc == 0 with key_ok (or key_valid) high, the round advances:
  - INIT_ROUND -> MID_ROUND.
  - MID_ROUND -> MID_ROUND while the completed round < Nr-1; otherwise -> LAST_ROUND.
  - LAST_ROUND -> IDLE.
  - key_idx steps +1 (encrypt) or -1 (decrypt); cyc reloads.
- At cyc == 0 without the key: stall, holding state, cyc and key_idx. req_key is not re-pulsed.
- mux_sel = 0 in INIT_ROUND, 1 in MID_ROUND and LAST_ROUND.
- mix_en = 1 only in MID_ROUND.
- busy = 1 in every non-IDLE state.
- done = 1 in the LAST_ROUND advancing cycle, combinational with that cycle; busy drops the next cycle.
- Latency with no stalls: start accepted at cycle T -> done at T + (Nr+1)*ROUND_CYCLES.
- start while busy is ignored, as are dir/key_len changes while busy.
- start in the done cycle is not accepted; it must be presented again in IDLE.
- abort in a non-IDLE state:
  - Next state IDLE; done stays 0.
  - key_idx, key_ok and cyc return to reset values.
  - abort has priority over round advance.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Optional Feature:
- AES_CTRL_STALL_CNT_EN defined:
  - stall_cycles port exists.
  - Cleared on start accept; +1 per key-wait stall cycle; saturates at all-ones; holds after done until the next start.
  - Reset value 0.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package aes_ctrl_pkg:
  - State enum aes_ctrl_state_e.
  - Key-length enum aes_key_len_e.
  - Constants NR_128 = 10, NR_192 = 12, NR_256 = 14.
  - Function nr_of(key_len).
- Sub-module aes_round_cycle_ctr:
  - Owns the load/decrement of cyc, key_ok capture, stall detection and the round_adv strobe.
  - The FSM consumes round_adv.

Test Plan:
- Encrypt AES-128, ROUND_CYCLES = 3, key_valid returned in the same cycle as every req_key.
  - done at T+33.
  - key_idx sequence 0..10; 11 req_key pulses.
  - mix_en high for exactly 27 cycles; mux_sel = 0 only for cycles T+1..T+3.
- Decrypt AES-256:
  - done at T+45.
  - key_idx sequence 14..0.
  - LAST_ROUND uses key_idx 0 with mix_en = 0.
- Key stall: AES-192 encrypt, key_valid for round 5 delayed 4 cycles past cyc == 0.
  - State, cyc and key_idx held for 4 cycles; done at T+39+4.
  - With the macro defined: stall_cycles = 4.
- abort asserted in MID_ROUND at round 6.
  - Next cycle IDLE, busy = 0, done never pulses.
  - A subsequent start runs a full 33-cycle operation.
- start held high during busy and during the done cycle.
  - No restart; accepted on the first IDLE cycle after done.
  - key_len = 3 yields a 10-round operation.
- reset asserted mid-round.
  - All outputs return to 0 immediately and stay 0 for the whole reset assertion.
